// File: rtl/gpio_cfg_writer.sv
// Transmit side of the PS->PL GPIO config-write protocol: buffers (addr, data)
// requests in a FWFT FIFO and serialises each onto gpio_out = {w_clk, data, addr}.
module gpio_cfg_writer #(
    parameter int unsigned ADDR_W        = 16,
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned WCLK_BIT      = 24,
    parameter int unsigned FIFO_AW       = 4,
    parameter int unsigned SETUP_CYCLES  = 4,
    parameter int unsigned STROBE_CYCLES = 4,
    parameter int unsigned GAP_CYCLES    = 4,
    // Reset value of words_sent; non-zero only in test builds exercising the wrap
    parameter logic [15:0] SENT_INIT     = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [DATA_W-1:0]    req_data,
    output logic [WCLK_BIT:0]    gpio_out,
    output logic                 busy,
    output logic [FIFO_AW:0]     fifo_count,
    output logic [15:0]          words_sent
);

    localparam int unsigned DEPTH = 2 ** FIFO_AW;
    localparam int unsigned PW    = ADDR_W + DATA_W;
    localparam int unsigned CW    = 16;

    localparam logic [CW-1:0] SETUP_LAST  = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] STROBE_LAST = CW'(STROBE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST    = CW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        GAP
    } state_t;

    state_t state, state_d;

    logic [PW-1:0]      mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               empty, full, push, pop;

    logic [CW-1:0]      phase, phase_d;
    logic [PW-1:0]      word_q;
    logic               wclk_q, wclk_d;
    logic               load, done;
    logic [15:0]        sent_q;

    // count never exceeds DEPTH, so its MSB alone marks full
    assign full      = count[FIFO_AW];
    assign empty     = (count == '0);
    assign req_ready = ~full & ~rst;
    assign push      = req_valid & req_ready;

    always_comb begin
        state_d = state;
        phase_d = phase;
        pop     = 1'b0;
        load    = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    load    = 1'b1;
                    phase_d = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (phase == SETUP_LAST) begin
                    phase_d = '0;
                    state_d = STROBE;
                end else begin
                    phase_d = phase + 1'b1;
                end
            end
            STROBE: begin
                if (phase == STROBE_LAST) begin
                    phase_d = '0;
                    state_d = GAP;
                end else begin
                    phase_d = phase + 1'b1;
                end
            end
            GAP: begin
                if (phase == GAP_LAST) begin
                    done    = 1'b1;
                    phase_d = '0;
                    if (!empty) begin
                        pop     = 1'b1;
                        load    = 1'b1;
                        state_d = SETUP;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    phase_d = phase + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Strobe is registered from the next state so it toggles only on phase edges
        wclk_d = (state_d == STROBE);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {req_data, req_addr};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            phase  <= '0;
            word_q <= '0;
            wclk_q <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            sent_q <= SENT_INIT;
        end else begin
            state  <= state_d;
            phase  <= phase_d;
            wclk_q <= wclk_d;
            if (load) begin
                word_q <= mem[rd_ptr];
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (done) begin
                sent_q <= sent_q + 1'b1;
            end
        end
    end

    always_comb begin
        gpio_out           = '0;
        gpio_out[PW-1:0]   = word_q;
        gpio_out[WCLK_BIT] = wclk_q;
    end

    assign busy       = (count != '0) || (state != IDLE);
    assign fifo_count = count;
    assign words_sent = sent_q;

endmodule

// File: tb/tb_gpio_cfg_writer.sv
// Directed bench for gpio_cfg_writer: default-timing instance plus a
// 1/1/1-timing instance whose words_sent resets to 0xFFFF to exercise the wrap.
module tb_gpio_cfg_writer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_valid = 1'b0, a_ready, a_busy;
    logic [15:0] a_addr = '0, a_ws;
    logic [7:0]  a_data = '0;
    logic [24:0] a_gpio;
    logic [4:0]  a_count;

    logic        b_valid = 1'b0, b_ready, b_busy;
    logic [15:0] b_addr = '0, b_ws;
    logic [7:0]  b_data = '0;
    logic [24:0] b_gpio;
    logic [4:0]  b_count;

    gpio_cfg_writer dut_a (
        .clk(clk), .rst(rst), .req_valid(a_valid), .req_ready(a_ready),
        .req_addr(a_addr), .req_data(a_data), .gpio_out(a_gpio), .busy(a_busy),
        .fifo_count(a_count), .words_sent(a_ws)
    );

    gpio_cfg_writer #(
        .SETUP_CYCLES(1), .STROBE_CYCLES(1), .GAP_CYCLES(1), .SENT_INIT(16'hFFFF)
    ) dut_b (
        .clk(clk), .rst(rst), .req_valid(b_valid), .req_ready(b_ready),
        .req_addr(b_addr), .req_data(b_data), .gpio_out(b_gpio), .busy(b_busy),
        .fifo_count(b_count), .words_sent(b_ws)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitors, sampled on the falling edge
    int          a_rise_cyc[$];
    logic [23:0] a_rise_word[$];
    int          a_stab_viol = 0;
    logic        a_prev_w = 1'b0;
    logic [23:0] a_prev_word = '0;
    int          b_rise_cyc[$];
    logic [23:0] b_rise_word[$];
    int          b_high = 0;
    logic        b_prev_w = 1'b0;
    logic        prev_rst = 1'b1;

    always @(negedge clk) begin
        if (!rst && !prev_rst) begin
            if (a_gpio[24] && !a_prev_w) begin
                a_rise_cyc.push_back(cyc);
                a_rise_word.push_back(a_gpio[23:0]);
            end
            if ((a_gpio[24] || a_prev_w) && (a_gpio[23:0] !== a_prev_word)) a_stab_viol++;
            if (b_gpio[24] && !b_prev_w) begin
                b_rise_cyc.push_back(cyc);
                b_rise_word.push_back(b_gpio[23:0]);
            end
            if (b_gpio[24]) b_high++;
        end
        a_prev_w    = a_gpio[24];
        a_prev_word = a_gpio[23:0];
        b_prev_w    = b_gpio[24];
        prev_rst    = rst;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [15:0] ad, input logic [7:0] d, output int acc);
        int w = 0;
        a_addr  = ad;
        a_data  = d;
        a_valid = 1'b1;
        while (!a_ready && w < 400) begin
            tick();
            w++;
        end
        if (!a_ready) check("push_a_timeout", 32'(a_ready), 32'd1);
        acc = cyc;
        tick();
        a_valid = 1'b0;
    endtask

    task automatic push_b(input logic [15:0] ad, input logic [7:0] d);
        int w = 0;
        b_addr  = ad;
        b_data  = d;
        b_valid = 1'b1;
        while (!b_ready && w < 400) begin
            tick();
            w++;
        end
        if (!b_ready) check("push_b_timeout", 32'(b_ready), 32'd1);
        tick();
        b_valid = 1'b0;
    endtask

    task automatic wait_idle_a(input int bound);
        int w = 0;
        while (a_busy && w < bound) begin
            tick();
            w++;
        end
        if (a_busy) check("idle_a_timeout", 32'(a_busy), 32'd0);
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        logic [24:0] setup_w;
        logic [24:0] strobe_w;
    } vec_t;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[4];
        int          t0, acc;
        int          acc_cyc[20];
        logic [15:0] exp_ws;
        logic [24:0] prev_w;
        logic [24:0] exp_g;

        tbl[0] = '{16'h0001, 8'hA5, 25'h00A50001, 25'h01A50001};
        tbl[1] = '{16'hFFFF, 8'hFF, 25'h00FFFFFF, 25'h01FFFFFF};
        tbl[2] = '{16'h0000, 8'h00, 25'h00000000, 25'h01000000};
        tbl[3] = '{16'h1234, 8'h5A, 25'h005A1234, 25'h015A1234};

        // ---- reset ----
        tick();
        tick();
        check("ready_in_rst", 32'(a_ready), 32'd0);
        check("rst_gpio", 32'(a_gpio), 32'd0);
        check("rst_count", 32'(a_count), 32'd0);
        check("rst_ws", 32'(a_ws), 32'd0);
        check("rst_busy", 32'(a_busy), 32'd0);
        check("rst_ws_b", 32'(b_ws), 32'hFFFF);
        rst = 1'b0;
        tick();
        check("ready_after_rst", 32'(a_ready), 32'd1);
        exp_ws = 16'd0;

        // ---- fast instance: 3-cycle period, 1-cycle strobe, words_sent wrap ----
        t0 = cyc;
        push_b(16'h0A00, 8'h11);
        push_b(16'h0A01, 8'h22);
        push_b(16'h0A02, 8'h33);
        while (cyc < t0 + 5) tick();
        check("b_ws_wrap", 32'(b_ws), 32'd0);
        while (cyc < t0 + 11) tick();
        check("b_ws_final", 32'(b_ws), 32'd2);
        check("b_busy_final", 32'(b_busy), 32'd0);
        check("b_high_cycles", 32'(b_high), 32'd3);
        check("b_rises", 32'(b_rise_cyc.size()), 32'd3);
        for (int k = 0; k < 3 && k < b_rise_cyc.size(); k++) begin
            check($sformatf("b_rise%0d_cyc", k), 32'(b_rise_cyc[k]), 32'(t0 + 3 + 3 * k));
            check($sformatf("b_rise%0d_word", k), 32'(b_rise_word[k]),
                  32'({8'h11 * 8'(k + 1), 16'h0A00 + 16'(k)}));
        end

        // ---- table: single writes through the default instance ----
        for (int i = 0; i < 4; i++) begin
            prev_w = (i == 0) ? 25'd0 : tbl[i - 1].setup_w;
            push_a(tbl[i].addr, tbl[i].data, acc);
            check($sformatf("vec%0d_hold", i), 32'(a_gpio), 32'(prev_w));
            tick();
            for (int c = 2; c <= 13; c++) begin
                exp_g = (c >= 6 && c <= 9) ? tbl[i].strobe_w : tbl[i].setup_w;
                check($sformatf("vec%0d_c%0d_gpio", i, c), 32'(a_gpio), 32'(exp_g));
                tick();
            end
            exp_ws = exp_ws + 16'd1;
            check($sformatf("vec%0d_busy", i), 32'(a_busy), 32'd0);
            check($sformatf("vec%0d_ws", i), 32'(a_ws), 32'(exp_ws));
        end

        // ---- back-to-back ----
        a_rise_cyc.delete();
        a_rise_word.delete();
        t0 = cyc;
        push_a(16'h0100, 8'h10, acc);
        push_a(16'h0101, 8'h20, acc);
        push_a(16'h0102, 8'h30, acc);
        wait_idle_a(100);
        exp_ws = exp_ws + 16'd3;
        check("b2b_ws", 32'(a_ws), 32'(exp_ws));
        check("b2b_rises", 32'(a_rise_cyc.size()), 32'd3);
        for (int k = 0; k < 3 && k < a_rise_cyc.size(); k++) begin
            check($sformatf("b2b_rise%0d_cyc", k), 32'(a_rise_cyc[k]), 32'(t0 + 6 + 12 * k));
            check($sformatf("b2b_rise%0d_word", k), 32'(a_rise_word[k]),
                  32'({8'h10 * 8'(k + 1), 16'h0100 + 16'(k)}));
        end
        check("b2b_stable", 32'(a_stab_viol), 32'd0);

        // ---- full FIFO: 20 consecutive requests ----
        // Pops at T+1 and T+13 leave 16 buffered after the push at T+17;
        // later requests wait for the pops at T+25 and T+37.
        a_rise_cyc.delete();
        a_rise_word.delete();
        t0 = cyc;
        for (int k = 0; k < 20; k++) begin
            if (k == 18) begin
                check("full_ready", 32'(a_ready), 32'd0);
                check("full_count", 32'(a_count), 32'd16);
            end
            push_a(16'h0200 + 16'(k), 8'h40 + 8'(k), acc_cyc[k]);
        end
        for (int k = 0; k < 18; k++)
            check($sformatf("full_acc%0d", k), 32'(acc_cyc[k] - t0), 32'(k));
        check("full_acc18", 32'(acc_cyc[18] - t0), 32'd26);
        check("full_acc19", 32'(acc_cyc[19] - t0), 32'd38);
        wait_idle_a(400);
        exp_ws = exp_ws + 16'd20;
        check("full_ws", 32'(a_ws), 32'(exp_ws));
        check("full_rises", 32'(a_rise_cyc.size()), 32'd20);
        for (int k = 0; k < 20 && k < a_rise_word.size(); k++)
            check($sformatf("full_word%0d", k), 32'(a_rise_word[k]),
                  32'({8'h40 + 8'(k), 16'h0200 + 16'(k)}));
        check("full_stable", 32'(a_stab_viol), 32'd0);

        // ---- reset while strobing with 5 words queued ----
        a_rise_cyc.delete();
        a_rise_word.delete();
        for (int k = 0; k < 6; k++) push_a(16'h0300 + 16'(k), 8'h60 + 8'(k), acc);
        check("rs_wclk_high", 32'(a_gpio[24]), 32'd1);
        check("rs_queued", 32'(a_count), 32'd5);
        rst = 1'b1;
        #1;
        check("rs_ready_low", 32'(a_ready), 32'd0);
        tick();
        rst = 1'b0;
        check("rs_gpio", 32'(a_gpio), 32'd0);
        check("rs_count", 32'(a_count), 32'd0);
        check("rs_ws", 32'(a_ws), 32'd0);
        check("rs_busy", 32'(a_busy), 32'd0);
        for (int k = 0; k < 40; k++) tick();
        check("rs_no_strobe", 32'(a_rise_cyc.size()), 32'd0);
        check("rs_gpio_quiet", 32'(a_gpio), 32'd0);
        push_a(16'h0400, 8'h77, acc);
        wait_idle_a(100);
        check("rs_resume_ws", 32'(a_ws), 32'd1);
        check("rs_resume_word", 32'(a_gpio), 32'h00770400);
        check("rs_stable", 32'(a_stab_viol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gpio_cfg_writer.md
Name: gpio_cfg_writer

Overview:
- Transmit end of the PS→PL GPIO configuration-write protocol.
- Accepts (address, data) write requests over a valid/ready handshake and buffers them in a FIFO.
- Serialises each request onto the 25-bit GPIO word:
  - addr in bits 15:0
  - data in bits 23:16
  - write strobe w_clk in bit 24
- Used to drive the config-register decoder from PL-side sequencers and in loopback benches, with timing that a synchronising receiver samples reliably.

Parameters:
- ADDR_W, 16, address field width; bits 15:0 of gpio_out.
- DATA_W, 8, data field width; bits 23:16 of gpio_out.
- WCLK_BIT, 24, bit index of the write strobe; gpio_out width is WCLK_BIT+1.
- FIFO_AW, 4, FIFO address width; depth is 2**FIFO_AW = 16 entries.
- SETUP_CYCLES, 4, cycles addr/data are held with w_clk=0 before the strobe; must be ≥1.
- STROBE_CYCLES, 4, cycles w_clk=1; must be ≥1.
- GAP_CYCLES, 4, cycles w_clk=0 after the strobe with addr/data still held; must be ≥1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  write request present.
- req_ready  out  1  FIFO can accept; equals !full.
- req_addr  in  ADDR_W  register address.
- req_data  in  DATA_W  register data.
- gpio_out  out  WCLK_BIT+1  GPIO word: {w_clk, data, addr}.
- busy  out  1  high when the FIFO is non-empty or the FSM is not in IDLE.
- fifo_count  out  FIFO_AW+1  entries currently buffered.
- words_sent  out  16  count of completed words; wraps 0xFFFF→0.

Behaviour:
- Reset (one clk edge with rst=1):
  - gpio_out=0, FIFO emptied, fifo_count=0, words_sent=0, FSM→IDLE, busy=0.
  - req_ready=0 while rst is high; req_ready=1 from the first cycle after rst drops.
- Reset mid-operation: the in-flight word and all buffered words are discarded; gpio_out (including w_clk) is 0 after the reset edge.
- Handshake: a push happens on an edge where req_valid & req_ready.
  - Push while full is impossible, because req_ready=0 while full, even if a pop occurs the same cycle.
  - Simultaneous push and pop on a non-full FIFO leaves fifo_count unchanged.
- FIFO: first-word-fall-through read data; read and write pointers wrap modulo depth; full when count = 2**FIFO_AW.
- FSM states: IDLE, SETUP, STROBE, GAP.
  - IDLE: w_clk=0; addr/data hold their last value (0 after reset). If the FIFO is non-empty, pop, load addr/data into gpio_out, phase counter←0, go to SETUP.
  - SETUP: w_clk=0 for SETUP_CYCLES cycles, then go to STROBE.
  - STROBE: w_clk=1 for STROBE_CYCLES cycles, then go to GAP.
  - GAP: w_clk=0 for GAP_CYCLES cycles. On the last GAP cycle:
    - increment words_sent;
    - if the FIFO is non-empty, pop and load the next word, go directly to SETUP;
    - otherwise go to IDLE.
- Addr/data bits change only on a load edge, never while w_clk=1 and never on the edge where w_clk changes.
- Latency: with an idle FIFO, a request accepted in cycle T makes gpio_out carry its addr/data from cycle T+2. w_clk rises at cycle T+2+SETUP_CYCLES.
- Back-to-back throughput: one word per SETUP_CYCLES+STROBE_CYCLES+GAP_CYCLES cycles (12 with defaults); no IDLE cycle between words.
- All outputs are registered; gpio_out has no combinational path from inputs.
- words_sent increments exactly once per strobe pulse.

Test Plan:
- Single write, defaults: push addr=0x0001 data=0xA5 at cycle T → gpio_out=0x00A50001 from T+2 to T+5; gpio_out=0x01A50001 for T+6..T+9; gpio_out=0x00A50001 for T+10..T+13; words_sent=1; busy=0 from T+14.
- Back-to-back: push 3 words consecutively (addr 0x0100/0x0101/0x0102, data 0x10/0x20/0x30) → w_clk rising edges exactly 12 cycles apart; data/addr stable around each strobe; words_sent=3.
- Full FIFO: hold the FSM busy and push 17 words → req_ready=0 after the 16th while fifo_count=16; the 17th is accepted only after the first pop. All 17 words emerge in order with no loss or duplication.
- Reset mid-strobe: assert rst for one cycle while w_clk=1 with 5 words queued → next cycle gpio_out=0, fifo_count=0, words_sent=0; no further strobes until new pushes.
- Parameter sweep SETUP=1, STROBE=1, GAP=1 → words emitted every 3 cycles; w_clk pulse width exactly 1 cycle.
- Counter wrap: force 65536 completed words (or preload words_sent=0xFFFF in a bench build) → words_sent reads 0 after the next completed word.
